// File: rtl/serial_frame_scheduler.sv
// Round-robin scheduler sharing one serial header+payload transmit path between two requesters.
// Optional build macro SFS_PARITY_EN appends an even-parity bit per frame, checked in a PAR state.
module serial_frame_scheduler #(
  parameter int HDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] sin,
  output logic [1:0] gnt,
  output logic       sout,
  output logic       outvalid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
`ifdef SFS_PARITY_EN
    S_PAR  = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  localparam logic [HDR_W-1:0] CNT_ONE  = {{(HDR_W-1){1'b0}}, 1'b1};
  localparam logic [HDR_W-1:0] HDR_LAST = HDR_W[HDR_W-1:0] - CNT_ONE;
`ifdef SFS_PARITY_EN
  localparam state_t S_TAIL = S_PAR;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_port;
  logic             r_rr;
  logic             w_pick;
  logic             w_bit;
  logic             w_req_g;
  logic             w_active;
  logic             w_abort;
  logic [HDR_W-2:0] r_hdr_sr;
  logic [HDR_W-1:0] w_len_nxt;
  logic [HDR_W-1:0] r_bcnt;
  logic [HDR_W-1:0] r_cnt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic             r_sout;
  logic             w_sout_nxt;
  logic             r_ov;
  logic             w_ov_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;
`ifdef SFS_PARITY_EN
  logic             r_par;
  logic             r_par_fail;
`endif

  assign w_bit     = sin[r_port];
  assign w_req_g   = req[r_port];
  // The last header bit comes straight from sin so the length is known at the final header edge.
  assign w_len_nxt = {r_hdr_sr, w_bit};
`ifdef SFS_PARITY_EN
  assign w_active  = (r_state == S_HDR) || (r_state == S_PAY) || (r_state == S_PAR);
`else
  assign w_active  = (r_state == S_HDR) || (r_state == S_PAY);
`endif
  assign w_abort   = w_active && !w_req_g;

  always_comb begin
    w_pick = r_rr;
    case (req)
      2'b01:   w_pick = 1'b0;
      2'b10:   w_pick = 1'b1;
      default: w_pick = r_rr;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) w_state_nxt = S_HDR;
        else              w_state_nxt = S_IDLE;
      end
      S_HDR: begin
        if (!w_req_g)                    w_state_nxt = S_IDLE;
        else if (r_bcnt != HDR_LAST)     w_state_nxt = S_HDR;
        else if (w_len_nxt != {HDR_W{1'b0}}) w_state_nxt = S_PAY;
        else                             w_state_nxt = S_TAIL;
      end
      S_PAY: begin
        // Exit on the last remaining bit so the down-counter never wraps.
        if (!w_req_g)             w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_ONE) w_state_nxt = S_TAIL;
        else                      w_state_nxt = S_PAY;
      end
`ifdef SFS_PARITY_EN
      S_PAR: begin
        if (!w_req_g) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_DONE;
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt = 2'b00;
    if (w_state_nxt == S_IDLE)  w_gnt_nxt = 2'b00;
    else if (r_state == S_IDLE) w_gnt_nxt = {w_pick, ~w_pick};
    else                        w_gnt_nxt = r_gnt;
    w_ov_nxt   = (r_state == S_PAY) && !w_abort;
    w_sout_nxt = w_ov_nxt && w_bit;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (r_state == S_DONE);
`ifdef SFS_PARITY_EN
    w_err_nxt  = w_abort || ((r_state == S_DONE) && r_par_fail);
`else
    w_err_nxt  = w_abort;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_port   <= 1'b0;
      r_rr     <= 1'b0;
      r_hdr_sr <= {(HDR_W-1){1'b0}};
      r_bcnt   <= {HDR_W{1'b0}};
      r_cnt    <= {HDR_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hdr_sr <= {(HDR_W-1){1'b0}};
          r_bcnt   <= {HDR_W{1'b0}};
          r_cnt    <= {HDR_W{1'b0}};
          if (req != 2'b00) r_port <= w_pick;
        end
        S_HDR: begin
          r_hdr_sr <= w_len_nxt[HDR_W-2:0];
          r_bcnt   <= r_bcnt + CNT_ONE;
          if (r_bcnt == HDR_LAST) r_cnt <= w_len_nxt;
        end
        S_PAY:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      // Completion and abort both hand the next tie to the other port.
      if (w_abort || (r_state == S_DONE)) r_rr <= ~r_port;
    end
  end

`ifdef SFS_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par      <= 1'b0;
      r_par_fail <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_par      <= 1'b0;
          r_par_fail <= 1'b0;
        end
        S_HDR, S_PAY: r_par      <= r_par ^ w_bit;
        S_PAR:        r_par_fail <= r_par ^ w_bit;
        default:      r_par      <= r_par;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_gnt  <= 2'b00;
      r_sout <= 1'b0;
      r_ov   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_sout <= w_sout_nxt;
      r_ov   <= w_ov_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign sout     = r_sout;
  assign outvalid = r_ov;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Directed testbench for serial_frame_scheduler (HDR_W=4); inputs change and outputs are sampled on negedge.
module tb_serial_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] sin;
  logic [1:0] gnt;
  logic       sout;
  logic       outvalid;
  logic       busy;
  logic       done;
  logic       err;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_frame_scheduler #(.HDR_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .sin(sin), .gnt(gnt), .sout(sout),
    .outvalid(outvalid), .busy(busy), .done(done), .err(err)
  );

  // Drives bit b on port p (the other port gets the inverse) and waits one cycle.
  task automatic drive_bit(input logic p, input logic b);
    if (p) sin = {b, ~b};
    else   sin = {~b, b};
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 2'b00; sin = 2'b00;
    @(negedge clk); @(negedge clk);
    checks++; if (gnt !== 2'b00)   begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (sout !== 1'b0)   begin failures++; $display("FAIL reset_sout got=%b exp=0", sout); end
    checks++; if (outvalid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", outvalid); end
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)    begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_frame();
    logic [3:0] hdr;
    logic [2:0] pay;
    hdr = 4'b0011; pay = 3'b101;
    req = 2'b01; sin = 2'b00;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int i = 3; i >= 0; i--) begin
      drive_bit(1'b0, hdr[i]);
      checks++; if (outvalid !== 1'b0) begin failures++; $display("FAIL single_hdr_ov bit=%0d got=%b exp=0", i, outvalid); end
    end
    for (int i = 2; i >= 0; i--) begin
      drive_bit(1'b0, pay[i]);
      checks++;
      if (outvalid !== 1'b1 || sout !== pay[i]) begin
        failures++; $display("FAIL single_pay bit=%0d got ov=%b sout=%b exp ov=1 sout=%b", i, outvalid, sout, pay[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || gnt !== 2'b00 || outvalid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done got done=%b gnt=%b ov=%b busy=%b exp 1 00 0 0", done, gnt, outvalid, busy);
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_round_robin();
    logic       exp_p;
    logic [3:0] hdr;
    logic [1:0] pay;
    hdr = 4'b0010;
    do_reset();
    req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      exp_p = (j == 1);
      pay   = exp_p ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (gnt !== {exp_p, ~exp_p}) begin failures++; $display("FAIL rr_gnt frame=%0d got=%b exp=%b", j, gnt, {exp_p, ~exp_p}); end
      for (int i = 3; i >= 0; i--) drive_bit(exp_p, hdr[i]);
      for (int i = 1; i >= 0; i--) begin
        drive_bit(exp_p, pay[i]);
        checks++;
        if (outvalid !== 1'b1 || sout !== pay[i]) begin
          failures++; $display("FAIL rr_pay frame=%0d bit=%0d got ov=%b sout=%b exp ov=1 sout=%b", j, i, outvalid, sout, pay[i]);
        end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || gnt !== 2'b00) begin
        failures++; $display("FAIL rr_done frame=%0d got done=%b gnt=%b exp 1 00", j, done, gnt);
      end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_zero_length();
    req = 2'b10;
    @(negedge clk);
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL zero_gnt got=%b exp=10", gnt); end
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, 1'b0);
      checks++;
      if (outvalid !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL zero_hdr cyc=%0d got ov=%b done=%b exp 0 0", i, outvalid, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || outvalid !== 1'b0) begin
      failures++; $display("FAIL zero_done got done=%b ov=%b exp 1 0", done, outvalid);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [3:0] hdr;
    hdr = 4'b0101;
    req = 2'b11;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_gnt got=%b exp=01", gnt); end
    for (int i = 3; i >= 0; i--) drive_bit(1'b0, hdr[i]);
    drive_bit(1'b0, 1'b1);
    checks++; if (outvalid !== 1'b1 || sout !== 1'b1) begin failures++; $display("FAIL abort_bit0 got ov=%b sout=%b exp 1 1", outvalid, sout); end
    req = 2'b10;
    drive_bit(1'b0, 1'b0);
    checks++;
    if (err !== 1'b1 || outvalid !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_err got err=%b ov=%b gnt=%b busy=%b done=%b exp 1 0 00 0 0", err, outvalid, gnt, busy, done);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || err !== 1'b0 || outvalid !== 1'b0) begin
      failures++; $display("FAIL abort_next_gnt got gnt=%b err=%b ov=%b exp 10 0 0", gnt, err, outvalid);
    end
    req = 2'b00;
    @(negedge clk);
    checks++; if (err !== 1'b1 || gnt !== 2'b00) begin failures++; $display("FAIL abort_hdr got err=%b gnt=%b exp 1 00", err, gnt); end
    @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_async_reset();
    logic [3:0] hdr;
    hdr = 4'b0011;
    req = 2'b01;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL arst_gnt got=%b exp=01", gnt); end
    for (int i = 3; i >= 0; i--) drive_bit(1'b0, hdr[i]);
    drive_bit(1'b0, 1'b1);
    checks++; if (outvalid !== 1'b1) begin failures++; $display("FAIL arst_pay got ov=%b exp=1", outvalid); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || sout !== 1'b0 || outvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL arst_outputs got gnt=%b sout=%b ov=%b busy=%b done=%b err=%b exp all 0",
                           gnt, sout, outvalid, busy, done, err);
    end
    @(negedge clk);
    rst = 1'b1;
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL arst_regrant got gnt=%b busy=%b done=%b err=%b exp 10 1 0 0", gnt, busy, done, err);
    end
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

`ifdef SFS_PARITY_EN
  task automatic test_parity();
    logic [3:0] hdr;
    logic [1:0] par_bits;
    hdr = 4'b0010;
    par_bits = 2'b10;
    req = 2'b01;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL par_gnt frame=%0d got=%b exp=01", j, gnt); end
      for (int i = 3; i >= 0; i--) drive_bit(1'b0, hdr[i]);
      for (int i = 0; i < 2; i++) begin
        drive_bit(1'b0, 1'b1);
        checks++; if (outvalid !== 1'b1 || sout !== 1'b1) begin failures++; $display("FAIL par_pay frame=%0d got ov=%b sout=%b exp 1 1", j, outvalid, sout); end
      end
      drive_bit(1'b0, par_bits[j]);
      checks++; if (outvalid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL par_state frame=%0d got ov=%b done=%b exp 0 0", j, outvalid, done); end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || err !== (j == 0)) begin
        failures++; $display("FAIL par_result frame=%0d got done=%b err=%b exp done=1 err=%b", j, done, err, (j == 0));
      end
    end
    req = 2'b00;
    @(negedge clk);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_zero_length();
    test_abort();
    test_async_reset();
`ifdef SFS_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
